bcd_time_keeper: RTL and testbench

Parametrised BCD time-of-day counter for the alarm-clock datapath. It keeps 24-hour time as BCD digits, with optional seconds. It supports validated parallel load, carry-free set-mode increments and a hold control. It produces 12/24-hour display digits plus wrap pulses that the alarm comparator and display driver consume.

---
 rtl/clock_pkg.sv | 11 +
 rtl/bcd_pair_inc.sv | 22 ++
 rtl/bcd_time_keeper.sv | 85 ++++++++
 tb/tb_bcd_time_keeper.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD digit type, time limits and load validation helper
package clock_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
  localparam int HR_NOON = 12;
  function automatic logic bcd_pair_valid(input bcd_digit_t t, input bcd_digit_t u, input int max);
    return (u <= 4'd9) && (int'(t) * 10 + int'(u) <= max);
  endfunction
endpackage

// File: rtl/bcd_pair_inc.sv
// bcd_pair_inc: combinational two-digit BCD modulo-(MAX+1) incrementer
module bcd_pair_inc
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  bcd_digit_t t,
  input  bcd_digit_t u,
  input  logic       en,
  output bcd_digit_t t_nx,
  output bcd_digit_t u_nx,
  output logic       carry
);
  localparam bcd_digit_t MAX_T = bcd_digit_t'(MAX / 10);
  localparam bcd_digit_t MAX_U = bcd_digit_t'(MAX % 10);
  logic at_max, u_top;
  assign at_max = (t == MAX_T) && (u == MAX_U);
  assign u_top  = u == 4'd9;
  assign carry  = en & at_max;
  assign u_nx   = !en ? u : (at_max | u_top) ? 4'd0 : u + 4'd1;
  assign t_nx   = !en ? t : at_max ? 4'd0 : u_top ? t + 4'd1 : t;
endmodule

// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: 24 h BCD time-of-day counter with load, set-mode increments and 12/24 h display
module bcd_time_keeper
  import clock_pkg::*;
#(
  parameter bit HAS_SECONDS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       hold,
  input  logic       load,
  input  bcd_digit_t ld_hh_t,
  input  bcd_digit_t ld_hh_u,
  input  bcd_digit_t ld_mm_t,
  input  bcd_digit_t ld_mm_u,
  input  bcd_digit_t ld_ss_t,
  input  bcd_digit_t ld_ss_u,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       mode_12h,
  output bcd_digit_t hh_t,
  output bcd_digit_t hh_u,
  output bcd_digit_t mm_t,
  output bcd_digit_t mm_u,
  output bcd_digit_t ss_t,
  output bcd_digit_t ss_u,
  output bcd_digit_t disp_h_t,
  output bcd_digit_t disp_h_u,
  output logic       pm,
  output logic       minute_wrap,
  output logic       day_wrap,
  output logic       load_err
);
  logic set_go, tick_go, ld_ok, s_c, m_c, h_c;
  bcd_digit_t s_t_nx, s_u_nx, m_t_nx, m_u_nx, h_t_nx, h_u_nx;
  logic [4:0] hh_bin, h12;
  assign set_go  = inc_hr | inc_min;
  assign tick_go = tick & !hold & !load & !set_go;
  assign ld_ok   = bcd_pair_valid(ld_hh_t, ld_hh_u, HR_MAX) && bcd_pair_valid(ld_mm_t, ld_mm_u, MIN_MAX)
                   && (!HAS_SECONDS || bcd_pair_valid(ld_ss_t, ld_ss_u, SEC_MAX));
  // without seconds the tick drives the minute stage directly
  generate
    if (HAS_SECONDS) begin : g_sec
      bcd_pair_inc #(.MAX(SEC_MAX)) u_sec (
        .t(ss_t), .u(ss_u), .en(tick_go), .t_nx(s_t_nx), .u_nx(s_u_nx), .carry(s_c)
      );
    end else begin : g_nosec
      assign s_t_nx = '0;
      assign s_u_nx = '0;
      assign s_c    = tick_go;
    end
  endgenerate
  bcd_pair_inc #(.MAX(MIN_MAX)) u_min (
    .t(mm_t), .u(mm_u), .en(set_go ? inc_min : s_c), .t_nx(m_t_nx), .u_nx(m_u_nx), .carry(m_c)
  );
  bcd_pair_inc #(.MAX(HR_MAX)) u_hr (
    .t(hh_t), .u(hh_u), .en(set_go ? inc_hr : m_c), .t_nx(h_t_nx), .u_nx(h_u_nx), .carry(h_c)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u} <= '0;
      {minute_wrap, day_wrap, load_err} <= '0;
    end else begin
      minute_wrap <= HAS_SECONDS ? s_c : 1'b0;
      day_wrap    <= tick_go & h_c;
      load_err    <= load & !ld_ok;
      if (load) begin
        if (ld_ok) begin
          {hh_t, hh_u, mm_t, mm_u} <= {ld_hh_t, ld_hh_u, ld_mm_t, ld_mm_u};
          ss_t <= HAS_SECONDS ? ld_ss_t : 4'd0;
          ss_u <= HAS_SECONDS ? ld_ss_u : 4'd0;
        end
      end else begin
        {hh_t, hh_u, mm_t, mm_u} <= {h_t_nx, h_u_nx, m_t_nx, m_u_nx};
        ss_t <= inc_min ? 4'd0 : s_t_nx;
        ss_u <= inc_min ? 4'd0 : s_u_nx;
      end
    end
  end
  assign hh_bin   = 5'(hh_t) * 5'd10 + 5'(hh_u);
  assign pm       = hh_bin >= 5'(HR_NOON);
  assign h12      = hh_bin == 5'd0 ? 5'(HR_NOON) : hh_bin > 5'(HR_NOON) ? hh_bin - 5'(HR_NOON) : hh_bin;
  assign disp_h_t = mode_12h ? (h12 >= 5'd10 ? 4'd1 : 4'd0) : hh_t;
  assign disp_h_u = mode_12h ? (h12 >= 5'd10 ? 4'(h12 - 5'd10) : 4'(h12)) : hh_u;
endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb_bcd_time_keeper: table-driven scoreboard bench for seconds and minutes-only builds
module tb_bcd_time_keeper;
  logic clk = 0, reset = 1, tick = 0, hold = 0, load = 0, inc_hr = 0, inc_min = 0, mode_12h = 0;
  logic [3:0] ld_hh_t = 0, ld_hh_u = 0, ld_mm_t = 0, ld_mm_u = 0, ld_ss_t = 0, ld_ss_u = 0;
  logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, disp_h_t, disp_h_u;
  logic pm, minute_wrap, day_wrap, load_err;
  logic [3:0] n_hh_t, n_hh_u, n_mm_t, n_mm_u, n_ss_t, n_ss_u, n_disp_h_t, n_disp_h_u;
  logic n_pm, n_minute_wrap, n_day_wrap, n_load_err;
  int total = 0, bad = 0;
  logic [35:0] exp_q[$];

  typedef struct {
    logic ld;
    logic [23:0] ld_d;
    logic tk, hd, ihr, imn, m12;
    logic [35:0] ex;
  } vec_t;
  vec_t tbl[$];

  bcd_time_keeper #(.HAS_SECONDS(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .hold(hold), .load(load),
    .ld_hh_t(ld_hh_t), .ld_hh_u(ld_hh_u), .ld_mm_t(ld_mm_t), .ld_mm_u(ld_mm_u),
    .ld_ss_t(ld_ss_t), .ld_ss_u(ld_ss_u), .inc_hr(inc_hr), .inc_min(inc_min), .mode_12h(mode_12h),
    .hh_t(hh_t), .hh_u(hh_u), .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
    .disp_h_t(disp_h_t), .disp_h_u(disp_h_u), .pm(pm),
    .minute_wrap(minute_wrap), .day_wrap(day_wrap), .load_err(load_err)
  );

  bcd_time_keeper #(.HAS_SECONDS(0)) dut_m (
    .clk(clk), .reset(reset), .tick(tick), .hold(hold), .load(load),
    .ld_hh_t(ld_hh_t), .ld_hh_u(ld_hh_u), .ld_mm_t(ld_mm_t), .ld_mm_u(ld_mm_u),
    .ld_ss_t(ld_ss_t), .ld_ss_u(ld_ss_u), .inc_hr(inc_hr), .inc_min(inc_min), .mode_12h(mode_12h),
    .hh_t(n_hh_t), .hh_u(n_hh_u), .mm_t(n_mm_t), .mm_u(n_mm_u), .ss_t(n_ss_t), .ss_u(n_ss_u),
    .disp_h_t(n_disp_h_t), .disp_h_u(n_disp_h_u), .pm(n_pm),
    .minute_wrap(n_minute_wrap), .day_wrap(n_day_wrap), .load_err(n_load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [35:0] main_out();
    return {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, disp_h_t, disp_h_u, pm, minute_wrap, day_wrap, load_err};
  endfunction

  function automatic logic [35:0] min_out();
    return {9'b0, n_hh_t, n_hh_u, n_mm_t, n_mm_u, n_ss_t, n_ss_u, n_minute_wrap, n_day_wrap, n_load_err};
  endfunction

  // expected: {hhmmss BCD, display hour BCD, pm, minute_wrap, day_wrap, load_err}
  function automatic vec_t mk(input logic ld, input logic [23:0] ld_d, input logic tk, hd, ihr, imn, m12,
                              input logic [23:0] st, input logic [7:0] dh, input logic [3:0] fl);
    vec_t v;
    v.ld = ld; v.ld_d = ld_d; v.tk = tk; v.hd = hd; v.ihr = ihr; v.imn = imn; v.m12 = m12;
    v.ex = {st, dh, fl};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic apply(input string nm, input vec_t v);
    load = v.ld; tick = v.tk; hold = v.hd; inc_hr = v.ihr; inc_min = v.imn; mode_12h = v.m12;
    {ld_hh_t, ld_hh_u, ld_mm_t, ld_mm_u, ld_ss_t, ld_ss_u} = v.ld_d;
    exp_q.push_back(v.ex);
    @(posedge clk);
    #1;
    load = 0; tick = 0; hold = 0; inc_hr = 0; inc_min = 0;
    chk(nm, main_out(), exp_q.pop_front());
  endtask

  initial begin
    tbl.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 0, 24'h000001, 8'h00, 4'b0000));
    tbl.push_back(mk(1, 24'h235958, 0, 0, 0, 0, 0, 24'h235958, 8'h23, 4'b1000));
    tbl.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 0, 24'h235959, 8'h23, 4'b1000));
    tbl.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 0, 24'h000000, 8'h00, 4'b0110));
    tbl.push_back(mk(0, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 8'h00, 4'b0000));
    tbl.push_back(mk(1, 24'h240000, 0, 0, 0, 0, 0, 24'h000000, 8'h00, 4'b0001));
    tbl.push_back(mk(1, 24'h126A00, 0, 0, 0, 0, 0, 24'h000000, 8'h00, 4'b0001));
    tbl.push_back(mk(1, 24'h095959, 0, 0, 0, 0, 0, 24'h095959, 8'h09, 4'b0000));
    tbl.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 0, 24'h100000, 8'h10, 4'b0100));
    tbl.push_back(mk(1, 24'h130500, 0, 0, 0, 0, 1, 24'h130500, 8'h01, 4'b1000));
    tbl.push_back(mk(0, 24'h000000, 0, 0, 0, 0, 0, 24'h130500, 8'h13, 4'b1000));
    tbl.push_back(mk(1, 24'h003000, 0, 0, 0, 0, 1, 24'h003000, 8'h12, 4'b0000));
    tbl.push_back(mk(1, 24'h120000, 0, 0, 0, 0, 1, 24'h120000, 8'h12, 4'b1000));
    tbl.push_back(mk(1, 24'h225940, 0, 0, 0, 0, 0, 24'h225940, 8'h22, 4'b1000));
    tbl.push_back(mk(0, 24'h000000, 1, 0, 1, 1, 0, 24'h230000, 8'h23, 4'b1000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 24'h000000, 1, 1, 0, 0, 0, 24'h230000, 8'h23, 4'b1000));
    tbl.push_back(mk(1, 24'h010203, 1, 0, 0, 1, 0, 24'h010203, 8'h01, 4'b0000));
    tbl.push_back(mk(1, 24'h236000, 1, 0, 0, 0, 0, 24'h010203, 8'h01, 4'b0001));
    tbl.push_back(mk(0, 24'h000000, 0, 0, 0, 1, 0, 24'h010300, 8'h01, 4'b0000));
    tbl.push_back(mk(0, 24'h000000, 1, 0, 1, 0, 0, 24'h020300, 8'h02, 4'b0000));
    tbl.push_back(mk(1, 24'h235930, 0, 0, 0, 0, 0, 24'h235930, 8'h23, 4'b1000));
    tbl.push_back(mk(0, 24'h000000, 0, 0, 1, 1, 0, 24'h000000, 8'h00, 4'b0000));
    tbl.push_back(mk(1, 24'h115959, 0, 0, 0, 0, 1, 24'h115959, 8'h11, 4'b0000));
    tbl.push_back(mk(0, 24'h000000, 1, 0, 0, 0, 1, 24'h120000, 8'h12, 4'b1100));
    tbl.push_back(mk(1, 24'h230000, 0, 0, 0, 0, 1, 24'h230000, 8'h11, 4'b1000));
    tbl.push_back(mk(1, 24'h095960, 0, 0, 0, 0, 0, 24'h230000, 8'h23, 4'b1001));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_24h", main_out(), 36'h0);
    chk("reset_min_build", min_out(), 36'h0);
    mode_12h = 1;
    #1;
    chk("reset_12h", main_out(), {24'h000000, 8'h12, 4'b0000});
    mode_12h = 0;
    reset = 0;

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // seconds digits out of range: rejected with seconds, accepted without
    apply("ld_bad_sec", mk(1, 24'h235999, 0, 0, 0, 0, 0, 24'h230000, 8'h23, 4'b1001));
    chk("min_ld_2359", min_out(), {9'b0, 24'h235900, 3'b000});
    apply("tick_main", mk(0, 24'h000000, 1, 0, 0, 0, 0, 24'h230001, 8'h23, 4'b1000));
    chk("min_day_wrap", min_out(), {9'b0, 24'h000000, 3'b010});
    apply("idle_main", mk(0, 24'h000000, 0, 0, 0, 0, 0, 24'h230001, 8'h23, 4'b1000));
    chk("min_pulse_end", min_out(), {9'b0, 24'h000000, 3'b000});

    apply("ld_074213", mk(1, 24'h074213, 0, 0, 0, 0, 0, 24'h074213, 8'h07, 4'b0000));
    #2 reset = 1;
    #1;
    chk("async_reset", main_out(), 36'h0);
    chk("async_reset_min", min_out(), 36'h0);
    #1 reset = 0;
    apply("tick_after_rst", mk(0, 24'h000000, 1, 0, 0, 0, 0, 24'h000001, 8'h00, 4'b0000));
    chk("min_tick_after_rst", min_out(), {9'b0, 24'h000100, 3'b000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
